argmax_sched: RTL

Sequencer in front of the 24-class argmax tree (3-cycle pipelined reduction, 192-bit score vector in, 8-bit score + 5-bit index out). Collects class scores streamed one per cycle from the final FC layer and packs them into the tree's input vector. Fires the tree once per frame and checks that its result returns in time. Runs a temporal stability filter on the winning index and publishes stable classifications downstream (display/UART) over a valid/ready handshake.

---
 rtl/argmax_sched_pkg.sv | 26 ++
 rtl/argmax_sched_stab_filter.sv | 53 +++++
 rtl/argmax_sched.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/argmax_sched_pkg.sv
// ============================================================================
// Module   : argmax_sched_pkg
// Brief    : Shared types and defaults for the argmax tree sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package argmax_sched_pkg;

    localparam int NUM_CLASS_DEF = 24;
    localparam int DATA_W_DEF    = 8;
    localparam int IDX_W_DEF     = 5;
    localparam int TREE_LAT_DEF  = 3;

    // Wide enough to hold the result timeout of TREE_LAT+2 cycles
    localparam int TMO_W = $clog2(TREE_LAT_DEF + 3);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FIRE    = 2'd1,
        WAIT    = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/argmax_sched_stab_filter.sv
// ============================================================================
// Module   : stab_filter
// Brief    : Temporal stability filter on the winning class index; built only
//            when ARGMAX_SCHED_STABLE_FILTER_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifdef ARGMAX_SCHED_STABLE_FILTER_EN
module stab_filter #(
    parameter int IDX_W      = 5,
    parameter int STABLE_CNT = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             step,
    input  logic [IDX_W-1:0] idx,
    output logic             publish
);

    logic [IDX_W-1:0] r_hist_idx;
    logic [3:0]       r_run;
    logic             r_hist_valid;
    logic             w_match;
    logic [3:0]       w_next_run;

    always_comb begin
        w_match    = r_hist_valid && (idx == r_hist_idx);
        w_next_run = 4'd1;
        if (w_match) begin
            w_next_run = (r_run == 4'd15) ? 4'd15 : r_run + 4'd1;
        end
        // A saturated run sitting at the threshold must not publish again
        publish = step && (w_next_run == 4'(STABLE_CNT))
                       && !(w_match && (r_run == 4'(STABLE_CNT)));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hist_idx   <= '0;
            r_run        <= 4'd0;
            r_hist_valid <= 1'b0;
        end else if (step) begin
            r_hist_idx   <= idx;
            r_run        <= w_next_run;
            r_hist_valid <= 1'b1;
        end
    end

endmodule
`endif

`default_nettype wire

// File: rtl/argmax_sched.sv
// ============================================================================
// Module   : argmax_sched
// Brief    : Collects per-class scores, fires the argmax tree once per frame,
//            watches for its result and publishes stable classifications.
//            Option macro: ARGMAX_SCHED_STABLE_FILTER_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module argmax_sched
    import argmax_sched_pkg::*;
#(
    parameter int NUM_CLASS  = NUM_CLASS_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int IDX_W      = IDX_W_DEF,
    parameter int TREE_LAT   = TREE_LAT_DEF,
    parameter int STABLE_CNT = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [DATA_W-1:0]           score_i,
    input  logic                        score_valid_i,
    input  logic                        score_last_i,
    output logic                        busy_o,
    output logic [NUM_CLASS*DATA_W-1:0] tree_data_o,
    output logic                        tree_valid_o,
    input  logic [DATA_W-1:0]           tree_data_i,
    input  logic [IDX_W-1:0]            tree_idx_i,
    input  logic                        tree_valid_i,
    output logic [IDX_W-1:0]            res_idx_o,
    output logic [DATA_W-1:0]           res_score_o,
    output logic                        res_valid_o,
    input  logic                        res_ready_i,
    output logic                        err_o,
    output logic                        drop_o
);

    localparam int CNT_W = $clog2(NUM_CLASS);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(NUM_CLASS - 1);
    localparam logic [TMO_W-1:0] c_tmo  = TMO_W'(TREE_LAT + 2);

    if (STABLE_CNT < 1 || STABLE_CNT > 15) begin : g_bad_stable_cnt
        $error("argmax_sched: STABLE_CNT must be in 1..15");
    end

    state_e                      r_state;
    logic [CNT_W-1:0]            r_cnt;
    logic [TMO_W-1:0]            r_tmo;
    logic [NUM_CLASS*DATA_W-1:0] r_vec;
    logic                        r_fire;
    logic                        r_err;
    logic                        r_drop;
    logic                        r_res_valid;
    logic [IDX_W-1:0]            r_res_idx;
    logic [DATA_W-1:0]           r_res_score;
    logic                        w_step;
    logic                        w_publish;

    assign w_step = (r_state == WAIT) && tree_valid_i;

`ifdef ARGMAX_SCHED_STABLE_FILTER_EN
    stab_filter #(
        .IDX_W      (IDX_W),
        .STABLE_CNT (STABLE_CNT)
    ) u_stab_filter (
        .clk     (clk),
        .resetn  (resetn),
        .step    (w_step),
        .idx     (tree_idx_i),
        .publish (w_publish)
    );
`else
    assign w_publish = w_step;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= COLLECT;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_vec       <= '0;
            r_fire      <= 1'b0;
            r_err       <= 1'b0;
            r_drop      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_idx   <= '0;
            r_res_score <= '0;
        end else begin
            r_fire <= 1'b0;
            r_err  <= 1'b0;
            r_drop <= 1'b0;
            if (r_res_valid && res_ready_i) begin
                r_res_valid <= 1'b0;
            end
            if (w_publish) begin
                if (!r_res_valid || res_ready_i) begin
                    r_res_valid <= 1'b1;
                    r_res_idx   <= tree_idx_i;
                    r_res_score <= tree_data_i;
                end else begin
                    r_drop <= 1'b1;
                end
            end

            case (r_state)
                COLLECT: begin
                    if (score_valid_i) begin
                        r_vec[int'(r_cnt)*DATA_W +: DATA_W] <= score_i;
                        if ((r_cnt == c_last) && score_last_i) begin
                            r_cnt   <= '0;
                            r_fire  <= 1'b1;
                            r_state <= FIRE;
                        end else if ((r_cnt == c_last) || score_last_i) begin
                            r_cnt <= '0;
                            r_err <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                FIRE: begin
                    r_err   <= score_valid_i;
                    r_tmo   <= c_tmo;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (tree_valid_i) begin
                        r_err   <= score_valid_i;
                        r_state <= COLLECT;
                    end else if (r_tmo == TMO_W'(1)) begin
                        r_err   <= 1'b1;
                        r_state <= COLLECT;
                    end else begin
                        r_err <= score_valid_i;
                        r_tmo <= r_tmo - 1'b1;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    assign busy_o       = (r_state != COLLECT);
    assign tree_data_o  = r_vec;
    assign tree_valid_o = r_fire;
    assign res_idx_o    = r_res_idx;
    assign res_score_o  = r_res_score;
    assign res_valid_o  = r_res_valid;
    assign err_o        = r_err;
    assign drop_o       = r_drop;

endmodule

`default_nettype wire
